// File: rtl/cdb_arbiter.sv
// Round-robin arbiter and registered driver for the common data bus (CDB).
// Define CDB_PERF_CNT_EN to add the perf_bcast / perf_stall counters.
module cdb_arbiter #(
  parameter int NREQ = 4,
  parameter int PTRW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [4*NREQ-1:0]    req_label,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 BCEN,
  output logic [3:0]           BClabel,
  output logic [31:0]          BCdata,
  output logic [PTRW-1:0]      BCsrc,
  output logic                 conflict,
  output logic                 err_label0
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_bcast,
  output logic [31:0]          perf_stall
`endif
);

  localparam int CNTW = $clog2(NREQ + 1);

  logic [PTRW-1:0] rr_ptr;
  logic [PTRW-1:0] ptr_next;
  logic [NREQ-1:0] grant;
  logic [PTRW-1:0] gnt_idx;
  logic            gnt_any;
  logic [3:0]      gnt_label;
  logic [31:0]     gnt_data;

  // NOTE: every variable gets a default before the search loop so no latch is inferred.
  always_comb begin : arbitrate
    int unsigned idx;
    grant     = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    gnt_label = '0;
    gnt_data  = '0;
    idx       = 0;
    if (!flush) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_ptr) + k) % NREQ;
        if (!gnt_any && req_valid[idx]) begin
          gnt_any    = 1'b1;
          grant[idx] = 1'b1;
          gnt_idx    = PTRW'(idx);
          gnt_label  = req_label[4*idx +: 4];
          gnt_data   = req_data[32*idx +: 32];
        end
      end
    end
  end

  // Grant is masked while reset is held so no unit retires into a dead bus.
  assign req_ready = nRST ? grant : '0;
  assign ptr_next  = (gnt_idx == PTRW'(NREQ - 1)) ? '0 : gnt_idx + PTRW'(1);

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rr_ptr     <= '0;
      BCEN       <= 1'b0;
      BClabel    <= '0;
      BCdata     <= '0;
      BCsrc      <= '0;
      conflict   <= 1'b0;
      err_label0 <= 1'b0;
    end else begin
      conflict <= !flush && ($countones(req_valid) > 1);
      if (gnt_any) begin
        rr_ptr <= ptr_next;
        if (gnt_label != 4'd0) begin
          BCEN    <= 1'b1;
          BClabel <= gnt_label;
          BCdata  <= gnt_data;
          BCsrc   <= gnt_idx;
        end else begin
          // Tag 0 is consumed but never broadcast; it flags a producer bug.
          BCEN       <= 1'b0;
          BClabel    <= '0;
          BCdata     <= '0;
          err_label0 <= 1'b1;
        end
      end else begin
        BCEN    <= 1'b0;
        BClabel <= '0;
        BCdata  <= '0;
      end
    end
  end

`ifdef CDB_PERF_CNT_EN
  logic [CNTW-1:0] stall_add;
  logic [32:0]     stall_sum;

  assign stall_add = CNTW'($countones(req_valid)) - CNTW'(gnt_any);
  assign stall_sum = {1'b0, perf_stall} + 33'(stall_add);

  // Both counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      perf_bcast <= '0;
      perf_stall <= '0;
    end else begin
      if (BCEN && perf_bcast != 32'hFFFF_FFFF) perf_bcast <= perf_bcast + 32'd1;
      perf_stall <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
    end
  end
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter and driver for the common data bus (CDB) in the Tomasulo core.
- Functional units (ALU, MUL/DIV, LOAD, ...) present finished results as {label, data}. One result per cycle is granted and driven as the registered broadcast triple BCEN/BClabel/BCdata.
- Every reservation-station queue and the register-status table snoop this triple.
- The arbiter also decouples unit completion from bus contention through a valid/ready handshake.

Parameters:
- NREQ, 4, number of requesting functional units; legal range 2..8.
- PTRW, $clog2(NREQ), width of the round-robin pointer and the source index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nRST  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash, for example on branch mispredict or exception.
- req_valid  input  NREQ  bit i: unit i holds a finished result.
- req_label  input  4*NREQ  flattened tag; slice i is bits [4i+3:4i]; tag 0 is reserved for "no tag".
- req_data  input  32*NREQ  flattened result value; slice i is bits [32i+31:32i].
- req_ready  output  NREQ  one-hot grant, combinational; unit i retires its result on the edge where valid and ready are both 1.
- BCEN  output  1  broadcast enable, registered.
- BClabel  output  4  broadcast tag, registered.
- BCdata  output  32  broadcast value, registered.
- BCsrc  output  PTRW  index of the unit that owns the current broadcast.
- conflict  output  1  registered; 1 when more than one req_valid bit was set in the previous cycle.
- err_label0  output  1  sticky; set when a tag-0 request is granted.

Behaviour:
- Reset (nRST low, asynchronous):
  - BCEN=0, BClabel=0, BCdata=0, BCsrc=0, conflict=0, err_label0=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is 0 while reset is held.
- Arbitration (combinational):
  - When flush=0, the grant goes to the first i with req_valid[i]=1, searching cyclically from rr_ptr through rr_ptr+NREQ-1 mod NREQ.
  - req_ready has at most one bit set. It depends only on req_valid, rr_ptr, flush and reset. It never depends on req_label or req_data.
- Broadcast:
  - Latency is 1 cycle: a grant at edge N drives BCEN=1, BClabel, BCdata and BCsrc for exactly the cycle after edge N.
  - No grant: next cycle BCEN=0, BClabel=0, BCdata=0; BCsrc holds.
  - Back-to-back grants give back-to-back broadcasts with no bubble.
- Pointer update:
  - On each grant, rr_ptr <= (granted index + 1) mod NREQ.
  - With no grant, or with flush, rr_ptr is unchanged.
  - This guarantees that a continuously valid requester waits at most NREQ-1 cycles.
- Tag 0:
  - A granted request with label 0 is consumed (ready=1) but not broadcast: BCEN=0 next cycle, BClabel=0.
  - err_label0 sets to 1 and stays set until reset.
  - The pointer still advances.
- Flush:
  - All req_ready=0 in the flush cycle.
  - At the next edge BCEN=0, BClabel=0, BCdata=0.
  - A broadcast already on the bus in the flush cycle stays valid for that cycle; it is not retracted.
  - Pending requesters keep valid and are served after flush deasserts.
- Handshake rules:
  - A requester must hold valid, label and data stable until ready.
  - Deasserting valid without ready is allowed. The arbiter keeps no per-request state.
- Reset asserted mid-broadcast: BCEN drops to 0 immediately (asynchronous) and the pending broadcast is lost. Units re-present their results after reset.
- conflict is updated every cycle from popcount(req_valid)>1, gated to 0 while flush=1.

Optional Feature:
- Macro: CDB_PERF_CNT_EN.
- When defined:
  - Extra 32-bit output ports perf_bcast and perf_stall.
  - perf_bcast increments on each cycle with BCEN=1.
  - perf_stall increments, each cycle, by the number of valid requesters not granted.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
  - Both are unaffected by flush.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset and single requester:
  - Assert nRST=0 mid-run → all outputs 0 immediately.
  - Release reset, then req_valid=0001, label0=5, data0=0x1234 → ready=0001 that cycle.
  - Next cycle BCEN=1, BClabel=5, BCdata=0x1234, BCsrc=0; the cycle after, BCEN=0.
- Full contention, NREQ=4:
  - req_valid=1111 held with labels 1,2,3,4 and each unit dropping valid after its grant.
  - Grants 0,1,2,3 on consecutive cycles; BClabel sequence 1,2,3,4 with no gap.
  - conflict=1 for the first three broadcast cycles.
- Fairness:
  - Unit 2 continuously valid while units 0 and 3 toggle valid every cycle → unit 2 is granted within 3 cycles of every previous grant.
  - The rr_ptr sequence matches the reference model.
- Tag 0: req_valid=0100, label2=0 → ready=0100; next cycle BCEN=0, err_label0=1 and it stays 1 through later normal traffic.
- Flush:
  - req_valid=0011 with flush=1 for 2 cycles → req_ready=0 and BCEN=0.
  - After flush drops, unit 0 is granted first (rr_ptr unchanged at 0), then unit 1.
- CDB_PERF_CNT_EN: 10 cycles of req_valid=1111 → perf_bcast=10 and perf_stall=30, excluding the final pipeline cycle.
